// File: rtl/mcu_pkg.sv
// Shared encodings for the MCU bank sequencer and the mux array it drives:
// phase codes, CONV sub-phase codes and port-width helpers.
package mcu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CONV = 2'd1,
        ST_READ = 2'd2
    } mcu_state_e;

    typedef enum logic [1:0] {
        SUB_FILL   = 2'd0,
        SUB_STREAM = 2'd1,
        SUB_DRAIN  = 2'd2
    } mcu_sub_e;

    function automatic int state_w();
        return $clog2(3);
    endfunction

    function automatic int substate_w(input int n);
        return $clog2(n / 2 + 1) + 1;
    endfunction

    function automatic int sel_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/mcu_writeback_delay.sv
// Delay line of (valid, output row) pairs that lines up each CONV write-back
// with the cycle its result reaches the mux input.
module mcu_writeback_delay #(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_row,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_row
);

    logic [LATENCY-1:0] r_valid;
    logic [ADDR_W-1:0]  r_row [LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic              w_valid_in;
            logic [ADDR_W-1:0] w_row_in;
            if (gi == 0) begin : g_head
                assign w_valid_in = i_valid;
                assign w_row_in   = i_row;
            end else begin : g_body
                assign w_valid_in = r_valid[gi-1];
                assign w_row_in   = r_row[gi-1];
            end
            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    r_valid[gi] <= 1'b0;
                    r_row[gi]   <= '0;
                end else begin
                    r_valid[gi] <= w_valid_in;
                    r_row[gi]   <= w_row_in;
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[LATENCY-1];
    assign o_row   = r_row[LATENCY-1];

endmodule

// File: rtl/mcu_bank_sequencer.sv
// Phase sequencer (LOAD -> CONV -> READ) for the MCU bank/convolution mux array.
// Optional frame counter output enabled by defining MCU_FRAME_CNT_EN.
module mcu_bank_sequencer
    import mcu_pkg::*;
#(
    parameter int N            = 2,
    parameter int BITS_IMAGEN  = 8,
    parameter int BITS_DATA    = 13,
    parameter int BITS_ADDR    = 10,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CONV_LATENCY = 3
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_outReady,
    output logic                     o_outValid,
    output logic [state_w()-1:0]     o_state,
    output logic [substate_w(N)-1:0] o_substate,
    output logic [sel_w(N)-1:0]      o_memSelect,
    output logic [N+1:0]             o_wrEnable,
    output logic [BITS_ADDR-1:0]     o_wrAddr,
    output logic [BITS_ADDR-1:0]     o_rdAddr,
    output logic                     o_done
`ifdef MCU_FRAME_CNT_EN
    ,
    output logic [15:0]              o_frameCount
`endif
);

    localparam int SEL_W = sel_w(N);
    localparam int SUB_W = substate_w(N);
    localparam int BANKS = N + 2;
    localparam logic [BITS_ADDR-1:0] LAST_ROW  = BITS_ADDR'(IMAGE_HEIGHT - 1);
    localparam logic [BITS_ADDR-1:0] LAST_OUT  = BITS_ADDR'(IMAGE_HEIGHT - 3);
    localparam logic [SEL_W-1:0]     LAST_BANK = SEL_W'(N + 1);
    localparam logic [SEL_W-1:0]     LAST_CONV = SEL_W'(N);
    localparam logic [BANKS-1:0]     CONV_MASK = {1'b0, {N{1'b1}}, 1'b0};

    // An unsupported parameter combination shows up as this block in the hierarchy.
    generate
        if (IMAGE_HEIGHT < 3 || CONV_LATENCY < 1 || (N % 2) != 0 || BITS_DATA < BITS_IMAGEN) begin : g_param_invalid
        end
    endgenerate

    mcu_state_e           r_state, w_state_next;
    mcu_sub_e             r_sub, w_sub_next;
    logic [BITS_ADDR-1:0] r_row, w_row_next;
    logic [SEL_W-1:0]     r_bank, w_bank_next;
    logic [BITS_ADDR-1:0] r_rd, w_rd_next;
    logic                 r_out_valid, w_out_valid_next;
    logic                 w_issue;
    logic [BITS_ADDR-1:0] w_issue_row;
    logic                 w_wb_valid;
    logic [BITS_ADDR-1:0] w_wb_row;

    mcu_writeback_delay #(
        .LATENCY (CONV_LATENCY),
        .ADDR_W  (BITS_ADDR)
    ) u_wb_delay (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (w_issue),
        .i_row   (w_issue_row),
        .o_valid (w_wb_valid),
        .o_row   (w_wb_row)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= ST_LOAD;
            r_sub       <= SUB_FILL;
            r_row       <= '0;
            r_bank      <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sub       <= w_sub_next;
            r_row       <= w_row_next;
            r_bank      <= w_bank_next;
            r_rd        <= w_rd_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sub_next       = r_sub;
        w_row_next       = r_row;
        w_bank_next      = r_bank;
        w_rd_next        = r_rd;
        w_out_valid_next = 1'b0;
        w_issue          = 1'b0;
        w_issue_row      = r_rd - BITS_ADDR'(2);
        o_ready          = 1'b0;
        o_outValid       = 1'b0;
        o_substate       = '0;
        o_memSelect      = '0;
        o_wrEnable       = '0;
        o_wrAddr         = '0;
        o_rdAddr         = '0;
        o_done           = 1'b0;
        case (r_state)
            ST_LOAD: begin
                o_ready     = 1'b1;
                o_memSelect = r_bank;
                if (i_valid) begin
                    o_wrEnable = BANKS'(1) << r_bank;
                    o_wrAddr   = r_row;
                    if (r_row == LAST_ROW) begin
                        w_row_next = '0;
                        if (r_bank == LAST_BANK) begin
                            w_bank_next  = '0;
                            w_rd_next    = '0;
                            w_sub_next   = SUB_FILL;
                            w_state_next = ST_CONV;
                        end else begin
                            w_bank_next = r_bank + SEL_W'(1);
                        end
                    end else begin
                        w_row_next = r_row + BITS_ADDR'(1);
                    end
                end
            end
            ST_CONV: begin
                o_substate = SUB_W'(r_sub);
                o_rdAddr   = r_rd;
                if (r_sub != SUB_DRAIN) begin
                    // Row k's window is complete once row k+2 has been read.
                    w_issue = (r_rd >= BITS_ADDR'(2));
                    if (r_rd == LAST_ROW) begin
                        w_sub_next = SUB_DRAIN;
                    end else begin
                        w_rd_next = r_rd + BITS_ADDR'(1);
                        if (r_rd == BITS_ADDR'(1)) w_sub_next = SUB_STREAM;
                    end
                end
                if (w_wb_valid) begin
                    o_wrEnable = CONV_MASK;
                    o_wrAddr   = w_wb_row;
                    if (w_wb_row == LAST_OUT) begin
                        w_state_next = ST_READ;
                        w_sub_next   = SUB_FILL;
                        w_rd_next    = '0;
                        w_bank_next  = SEL_W'(1);
                    end
                end
            end
            ST_READ: begin
                o_memSelect = r_bank;
                o_rdAddr    = r_rd;
                o_outValid  = r_out_valid;
                // Each new address needs one cycle of bank read latency before valid.
                if (r_out_valid && i_outReady) begin
                    if (r_rd == LAST_OUT) begin
                        w_rd_next = '0;
                        if (r_bank == LAST_CONV) begin
                            o_done       = 1'b1;
                            w_bank_next  = '0;
                            w_state_next = ST_LOAD;
                        end else begin
                            w_bank_next = r_bank + SEL_W'(1);
                        end
                    end else begin
                        w_rd_next = r_rd + BITS_ADDR'(1);
                    end
                end else begin
                    w_out_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    assign o_state = state_w()'(r_state);

`ifdef MCU_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_frame_cnt <= '0;
        else if (o_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
    assign o_frameCount = r_frame_cnt;
`endif

endmodule

// File: tb/tb_mcu_bank_sequencer.sv
// Directed bench for mcu_bank_sequencer (N=2, H=4): unit A uses CONV_LATENCY=1,
// unit B uses CONV_LATENCY=3; both share stimulus.
module tb_mcu_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       a_ready, a_out_valid, a_done;
    logic [1:0] a_state, a_sub, a_sel;
    logic [3:0] a_we;
    logic [9:0] a_wr_addr, a_rd_addr;
    logic       b_ready, b_out_valid, b_done;
    logic [1:0] b_state, b_sub, b_sel;
    logic [3:0] b_we;
    logic [9:0] b_wr_addr, b_rd_addr;
`ifdef MCU_FRAME_CNT_EN
    logic [15:0] a_frame, b_frame;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcu_bank_sequencer #(.N(2), .BITS_ADDR(10), .IMAGE_HEIGHT(4), .CONV_LATENCY(1)) dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(a_ready),
        .i_outReady(out_ready), .o_outValid(a_out_valid), .o_state(a_state),
        .o_substate(a_sub), .o_memSelect(a_sel), .o_wrEnable(a_we),
        .o_wrAddr(a_wr_addr), .o_rdAddr(a_rd_addr), .o_done(a_done)
`ifdef MCU_FRAME_CNT_EN
        , .o_frameCount(a_frame)
`endif
    );

    mcu_bank_sequencer #(.N(2), .BITS_ADDR(10), .IMAGE_HEIGHT(4), .CONV_LATENCY(3)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(b_ready),
        .i_outReady(out_ready), .o_outValid(b_out_valid), .o_state(b_state),
        .o_substate(b_sub), .o_memSelect(b_sel), .o_wrEnable(b_we),
        .o_wrAddr(b_wr_addr), .o_rdAddr(b_rd_addr), .o_done(b_done)
`ifdef MCU_FRAME_CNT_EN
        , .o_frameCount(b_frame)
`endif
    );

    task automatic step(input logic v, input logic rdy);
        @(negedge clk);
        valid = v;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if ({a_state, a_sub, a_sel, a_we, a_wr_addr, a_rd_addr, a_ready, a_out_valid, a_done} !==
            {2'd0, 2'd0, 2'd0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got st=%0d sub=%0d sel=%0d we=%b wa=%0d ra=%0d rdy=%b ov=%b done=%b want all 0 except rdy=1",
                     a_state, a_sub, a_sel, a_we, a_wr_addr, a_rd_addr, a_ready, a_out_valid, a_done);
        end
`ifdef MCU_FRAME_CNT_EN
        checks++;
        if (a_frame !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_count got %0d want 0", a_frame);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_load_full();
        logic [3:0] exp_we;
        for (int p = 0; p < 16; p++) begin
            step(1'b1, 1'b0);
            exp_we = 4'b0001 << (p / 4);
            checks++;
            if ({a_state, a_ready, a_sel, a_we, a_wr_addr} !== {2'd0, 1'b1, 2'(p / 4), exp_we, 10'(p % 4)}) begin
                failures++;
                $display("FAIL load_pixel%0d got st=%0d rdy=%b sel=%0d we=%b wa=%0d want st=0 rdy=1 sel=%0d we=%b wa=%0d",
                         p, a_state, a_ready, a_sel, a_we, a_wr_addr, p / 4, exp_we, p % 4);
            end
        end
    endtask

    // Runs both latencies side by side: A spends 5 cycles in CONV, B spends 7.
    task automatic test_conv();
        logic [1:0] exp_sub;
        logic [3:0] exp_we;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b0);
            exp_sub = (c < 2) ? 2'd0 : (c < 4) ? 2'd1 : 2'd2;
            if (c < 5) begin
                exp_we = (c >= 3) ? 4'b0110 : 4'b0000;
                checks++;
                if ({a_state, a_ready, a_sub, a_we} !== {2'd1, 1'b0, exp_sub, exp_we}) begin
                    failures++;
                    $display("FAIL conv_a_c%0d got st=%0d rdy=%b sub=%0d we=%b want st=1 rdy=0 sub=%0d we=%b",
                             c, a_state, a_ready, a_sub, a_we, exp_sub, exp_we);
                end
                if (c < 4) begin
                    checks++;
                    if (a_rd_addr !== 10'(c)) begin
                        failures++;
                        $display("FAIL conv_a_rdaddr_c%0d got %0d want %0d", c, a_rd_addr, c);
                    end
                end
                if (c >= 3) begin
                    checks++;
                    if (a_wr_addr !== 10'(c - 3)) begin
                        failures++;
                        $display("FAIL conv_a_wraddr_c%0d got %0d want %0d", c, a_wr_addr, c - 3);
                    end
                end
            end else begin
                checks++;
                if ({a_state, a_sel, a_rd_addr, a_we} !== {2'd2, 2'd1, 10'd0, 4'd0}) begin
                    failures++;
                    $display("FAIL conv_a_to_read_c%0d got st=%0d sel=%0d ra=%0d we=%b want st=2 sel=1 ra=0 we=0000",
                             c, a_state, a_sel, a_rd_addr, a_we);
                end
            end
            if (c < 7) begin
                exp_we = (c >= 5) ? 4'b0110 : 4'b0000;
                checks++;
                if ({b_state, b_sub, b_we} !== {2'd1, exp_sub, exp_we}) begin
                    failures++;
                    $display("FAIL conv_b_c%0d got st=%0d sub=%0d we=%b want st=1 sub=%0d we=%b",
                             c, b_state, b_sub, b_we, exp_sub, exp_we);
                end
                if (c >= 5) begin
                    checks++;
                    if (b_wr_addr !== 10'(c - 5)) begin
                        failures++;
                        $display("FAIL conv_b_wraddr_c%0d got %0d want %0d", c, b_wr_addr, c - 5);
                    end
                end
            end else begin
                checks++;
                if (b_state !== 2'd2) begin
                    failures++;
                    $display("FAIL conv_b_to_read got st=%0d want 2", b_state);
                end
            end
        end
    endtask

    task automatic test_read_stall();
        int done_seen = 0;
        int guard;
        logic [1:0] exp_sel;
        logic [9:0] exp_ra;
        for (int w = 0; w < 4; w++) begin
            exp_sel = 2'(1 + w / 2);
            exp_ra  = 10'(w % 2);
            guard = 0;
            while (guard < 4) begin
                checks++;
                if ({a_state, a_sel, a_rd_addr, a_we} !== {2'd2, exp_sel, exp_ra, 4'd0}) begin
                    failures++;
                    $display("FAIL read_addr_w%0d got st=%0d sel=%0d ra=%0d we=%b want st=2 sel=%0d ra=%0d we=0000",
                             w, a_state, a_sel, a_rd_addr, a_we, exp_sel, exp_ra);
                end
                if (a_out_valid) break;
                step(1'b0, 1'b0);
                guard++;
            end
            checks++;
            if (guard >= 4) begin
                failures++;
                $display("FAIL read_valid_timeout_w%0d got no o_outValid want o_outValid within 4 cycles", w);
            end
            if (w == 1) begin
                for (int s = 0; s < 3; s++) begin
                    step(1'b0, 1'b0);
                    checks++;
                    if ({a_out_valid, a_sel, a_rd_addr, a_done} !== {1'b1, 2'd1, 10'd1, 1'b0}) begin
                        failures++;
                        $display("FAIL read_stall_s%0d got ov=%b sel=%0d ra=%0d done=%b want ov=1 sel=1 ra=1 done=0",
                                 s, a_out_valid, a_sel, a_rd_addr, a_done);
                    end
                end
            end
            step(1'b0, 1'b1);
            if (a_done) done_seen++;
            checks++;
            if (a_done !== (w == 3)) begin
                failures++;
                $display("FAIL read_done_w%0d got %b want %b", w, a_done, (w == 3));
            end
            step(1'b0, 1'b0);
            if (a_done) done_seen++;
        end
        checks++;
        if ({a_state, a_ready, a_done, a_out_valid} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL read_to_load got st=%0d rdy=%b done=%b ov=%b want st=0 rdy=1 done=0 ov=0",
                     a_state, a_ready, a_done, a_out_valid);
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL read_done_count got %0d want 1", done_seen);
        end
`ifdef MCU_FRAME_CNT_EN
        checks++;
        if (a_frame !== 16'd1) begin
            failures++;
            $display("FAIL frame_after_one got %0d want 1", a_frame);
        end
`endif
    endtask

    task automatic test_reset_in_conv();
        for (int p = 0; p < 16; p++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (a_state !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset_conv got st=%0d want 1", a_state);
        end
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if ({a_state, a_we, a_ready, a_sub, a_rd_addr} !== {2'd0, 4'd0, 1'b1, 2'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_in_conv got st=%0d we=%b rdy=%b sub=%0d ra=%0d want st=0 we=0000 rdy=1 sub=0 ra=0",
                     a_state, a_we, a_ready, a_sub, a_rd_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_toggle_load();
        int writes = 0;
        int done_seen = 0;
        int p;
        logic v;
        logic [3:0] exp_we;
        for (int i = 0; i < 32; i++) begin
            v = ((i % 2) == 0);
            step(v, 1'b0);
            p = i / 2;
            if (a_we !== 4'd0) writes++;
            if (v) begin
                exp_we = 4'b0001 << (p / 4);
                checks++;
                if ({a_we, a_wr_addr} !== {exp_we, 10'(p % 4)}) begin
                    failures++;
                    $display("FAIL toggle_write_p%0d got we=%b wa=%0d want we=%b wa=%0d",
                             p, a_we, a_wr_addr, exp_we, p % 4);
                end
            end else if (i < 31) begin
                checks++;
                if ({a_state, a_we, a_sel} !== {2'd0, 4'd0, 2'(((i + 1) / 2) / 4)}) begin
                    failures++;
                    $display("FAIL toggle_idle_i%0d got st=%0d we=%b sel=%0d want st=0 we=0000 sel=%0d",
                             i, a_state, a_we, a_sel, ((i + 1) / 2) / 4);
                end
            end else begin
                checks++;
                if ({a_state, a_ready} !== {2'd1, 1'b0}) begin
                    failures++;
                    $display("FAIL toggle_to_conv got st=%0d rdy=%b want st=1 rdy=0", a_state, a_ready);
                end
            end
        end
        checks++;
        if (writes != 16) begin
            failures++;
            $display("FAIL toggle_write_count got %0d want 16", writes);
        end
        for (int c = 0; c < 40 && done_seen == 0; c++) begin
            step(1'b0, 1'b1);
            if (a_done) done_seen++;
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL toggle_frame_done got %0d want 1 within 40 cycles", done_seen);
        end
    endtask

    task automatic test_frames();
        int dones = 0;
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int seen = 0;
            for (int p = 0; p < 16; p++) step(1'b1, 1'b1);
            for (int c = 0; c < 40 && seen == 0; c++) begin
                step(1'b0, 1'b1);
                if (a_done) seen++;
            end
            checks++;
            if (seen != 1) begin
                failures++;
                $display("FAIL frame%0d_done got %0d want 1 within 40 cycles", f, seen);
            end
            dones += seen;
        end
        step(1'b0, 1'b0);
        checks++;
        if (dones != 3) begin
            failures++;
            $display("FAIL frames_done_total got %0d want 3", dones);
        end
`ifdef MCU_FRAME_CNT_EN
        checks++;
        if (a_frame !== 16'd3) begin
            failures++;
            $display("FAIL frame_count got %0d want 3", a_frame);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_conv();
        test_read_stall();
        test_reset_in_conv();
        test_toggle_load();
        test_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
